// File: rtl/riscv_rfarb.sv
// riscv_rfarb: arbitrates the single register-file write port between the
// pipeline writeback stage and a small FIFO of long-latency results
// (mul/div, load refill). Writeback normally wins. A buffered result whose
// destination is overwritten by a younger writeback is invalidated and
// dropped without a port write.
// Optional feature: define RISCV_RFARB_STARVE_EN to add starvation
// protection. After STARVE_MAX consecutive losses the buffer head is forced
// through and the pipeline is stalled for that cycle.
module riscv_rfarb #(
  parameter int LU_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_riscv_rfarb_clk,
  input  logic        i_riscv_rfarb_rst_n,
  input  logic        i_riscv_rfarb_wb_we,
  input  logic [4:0]  i_riscv_rfarb_wb_rdaddr,
  input  logic [63:0] i_riscv_rfarb_wb_rddata,
  input  logic        i_riscv_rfarb_lu_valid,
  input  logic [4:0]  i_riscv_rfarb_lu_rdaddr,
  input  logic [63:0] i_riscv_rfarb_lu_rddata,
  output logic        o_riscv_rfarb_lu_ready,
  output logic        o_riscv_rfarb_regwrite,
  output logic [4:0]  o_riscv_rfarb_rdaddr,
  output logic [63:0] o_riscv_rfarb_rddata,
  output logic        o_riscv_rfarb_stall
);

  localparam int            PW       = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam logic [2:0]    DEPTH_C  = 3'(LU_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(LU_DEPTH - 1);

  logic [4:0]          r_buf_addr [LU_DEPTH];
  logic [63:0]         r_buf_data [LU_DEPTH];
  logic [LU_DEPTH-1:0] r_buf_vld;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_wr_ptr;
  logic [2:0]          r_count;

  logic w_wb_act;
  logic w_head_present;
  logic w_head_valid;
  logic w_force;
  logic w_grant_wb;
  logic w_grant_head;
  logic w_pop;
  logic w_push;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A write to x0 is not a request; the port counts as free from WB.
  assign w_wb_act       = i_riscv_rfarb_wb_we && (i_riscv_rfarb_wb_rdaddr != 5'd0);
  assign w_head_present = (r_count != 3'd0);
  assign w_head_valid   = w_head_present && r_buf_vld[r_rd_ptr];

  // Ready is based on the registered count only, so a pop in this cycle does
  // not free a slot until the next one. Held low while reset is asserted.
  assign o_riscv_rfarb_lu_ready = i_riscv_rfarb_rst_n && (r_count < DEPTH_C);

  // Results to x0 are accepted and then dropped.
  assign w_push = i_riscv_rfarb_lu_valid && o_riscv_rfarb_lu_ready &&
                  (i_riscv_rfarb_lu_rdaddr != 5'd0);

  // Per-cycle winner selection: a forced head, then WB, then a valid head.
  always_comb begin
    w_grant_wb   = 1'b0;
    w_grant_head = 1'b0;
    if (w_force) begin
      w_grant_head = 1'b1;
    end else if (w_wb_act) begin
      w_grant_wb = 1'b1;
    end else if (w_head_valid) begin
      w_grant_head = 1'b1;
    end
  end

  // An invalidated head leaves in one cycle, alongside any WB grant.
  assign w_pop = w_grant_head || (w_head_present && !r_buf_vld[r_rd_ptr]);

  // Result FIFO: push, pop and invalidation by a same-address WB write.
  always_ff @(posedge i_riscv_rfarb_clk or negedge i_riscv_rfarb_rst_n) begin
    if (!i_riscv_rfarb_rst_n) begin
      for (int i = 0; i < LU_DEPTH; i++) begin
        r_buf_addr[i] <= 5'd0;
        r_buf_data[i] <= 64'd0;
      end
      r_buf_vld <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= 3'd0;
    end else begin
      // Unoccupied slots may be cleared too; a push always re-validates them.
      if (w_grant_wb) begin
        for (int i = 0; i < LU_DEPTH; i++) begin
          if (r_buf_addr[i] == i_riscv_rfarb_wb_rdaddr) begin
            r_buf_vld[i] <= 1'b0;
          end
        end
      end
      // Placed after the kill loop so an entry accepted this cycle survives.
      if (w_push) begin
        r_buf_addr[r_wr_ptr] <= i_riscv_rfarb_lu_rdaddr;
        r_buf_data[r_wr_ptr] <= i_riscv_rfarb_lu_rddata;
        r_buf_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr             <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  // Registered write port; address and data hold when nothing is granted.
  always_ff @(posedge i_riscv_rfarb_clk or negedge i_riscv_rfarb_rst_n) begin
    if (!i_riscv_rfarb_rst_n) begin
      o_riscv_rfarb_regwrite <= 1'b0;
      o_riscv_rfarb_rdaddr   <= 5'd0;
      o_riscv_rfarb_rddata   <= 64'd0;
    end else if (w_grant_wb) begin
      o_riscv_rfarb_regwrite <= 1'b1;
      o_riscv_rfarb_rdaddr   <= i_riscv_rfarb_wb_rdaddr;
      o_riscv_rfarb_rddata   <= i_riscv_rfarb_wb_rddata;
    end else if (w_grant_head) begin
      o_riscv_rfarb_regwrite <= 1'b1;
      o_riscv_rfarb_rdaddr   <= r_buf_addr[r_rd_ptr];
      o_riscv_rfarb_rddata   <= r_buf_data[r_rd_ptr];
    end else begin
      o_riscv_rfarb_regwrite <= 1'b0;
    end
  end

`ifdef RISCV_RFARB_STARVE_EN
  localparam int            CW     = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] r_starve_cnt;

  // Gated by head validity so a stale saturated count never stalls on a
  // killed head that is only being drained.
  assign w_force = w_head_valid && (r_starve_cnt == SMAX_C);

  // Count consecutive losses of a valid head to WB; saturating.
  always_ff @(posedge i_riscv_rfarb_clk or negedge i_riscv_rfarb_rst_n) begin
    if (!i_riscv_rfarb_rst_n) begin
      r_starve_cnt <= '0;
    end else if (!w_head_present || w_grant_head) begin
      r_starve_cnt <= '0;
    end else if (w_head_valid && w_grant_wb && (r_starve_cnt != SMAX_C)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign o_riscv_rfarb_stall = w_force;

endmodule

// File: doc/riscv_rfarb.md
RISCV_RFARB -- requirements
Module: riscv_rfarb

Interface
REQ-001 Parameter LU_DEPTH, default 2: long-latency result buffer depth in entries, range 1..4.
REQ-002 Parameter STARVE_MAX, default 4: consecutive buffer-head losses before a forced grant; used only under the configuration macro.
REQ-003 i_riscv_rfarb_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_riscv_rfarb_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_riscv_rfarb_wb_we  in  1  pipeline writeback write request.
REQ-006 i_riscv_rfarb_wb_rdaddr  in  5  pipeline destination register.
REQ-007 i_riscv_rfarb_wb_rddata  in  64  pipeline writeback data.
REQ-008 i_riscv_rfarb_lu_valid  in  1  long-latency unit result valid (mul/div, load refill).
REQ-009 i_riscv_rfarb_lu_rdaddr  in  5  long-latency destination register.
REQ-010 i_riscv_rfarb_lu_rddata  in  64  long-latency result data.
REQ-011 o_riscv_rfarb_lu_ready  out  1  buffer can accept a long-latency result this cycle.
REQ-012 o_riscv_rfarb_regwrite  out  1  write enable to the register file write port.
REQ-013 o_riscv_rfarb_rdaddr  out  5  register file write address.
REQ-014 o_riscv_rfarb_rddata  out  64  register file write data.
REQ-015 o_riscv_rfarb_stall  out  1  pipeline must hold its writeback request this cycle.

Function
REQ-016 WB request SHALL be active only when wb_we=1 and wb_rdaddr!=0; otherwise the port counts as free from WB.
REQ-017 LU handshake SHALL occur on lu_valid && lu_ready; lu_ready SHALL be 1 iff buffer count < LU_DEPTH (registered count, no same-cycle pop-through).
REQ-018 An accepted LU result with lu_rdaddr=0 SHALL be consumed and discarded, never enqueued.
REQ-019 The buffer SHALL be FIFO-ordered; an entry accepted in cycle N SHALL be eligible for grant no earlier than cycle N+1.
REQ-020 Arbitration SHALL be per cycle: an active WB request wins over the buffer head unless a forced grant is in effect (REQ-030); the head is granted only when WB is inactive or WB is stalled.
REQ-021 The grant SHALL be registered: the winner's address/data appear on o_riscv_rfarb_rdaddr/rddata with regwrite=1 exactly one cycle after the grant cycle; with no winner, regwrite=0 and address/data hold their previous values.
REQ-022 A granted head SHALL be popped in the grant cycle; push and pop in the same cycle SHALL leave count unchanged.
REQ-023 When WB is granted with address A, every buffered entry (present before this cycle) with rdaddr=A SHALL be invalidated and skipped without a port write; an LU entry accepted in that same cycle SHALL NOT be invalidated.
REQ-024 Invalidated entries SHALL still occupy count until they reach the head, where they are popped in one cycle without a grant; WB is not blocked by this pop.
REQ-025 regwrite SHALL never be 1 with rdaddr=0.

Reset
REQ-026 While rst_n=0: regwrite=0, rdaddr=0, rddata=0, stall=0, lu_ready=0, buffer empty, all entries invalid, starvation counter=0.
REQ-027 Reset assertion mid-operation SHALL discard all buffered results and any pending registered write; the first post-reset cycle SHALL show regwrite=0 and lu_ready=1.

Configuration
REQ-028 Macro RISCV_RFARB_STARVE_EN SHALL select starvation protection.
REQ-029 With the macro defined, a counter SHALL increment each cycle the valid head loses to WB, SHALL clear on any head grant or when the buffer is empty, and SHALL saturate at STARVE_MAX.
REQ-030 With the macro defined and counter=STARVE_MAX, the head SHALL be granted that cycle regardless of WB, and stall=1 (combinational from the counter register) for that cycle only.
REQ-031 Without the macro, strict WB priority SHALL apply, no counter SHALL exist, and stall SHALL be tied 0.

Verification
REQ-032 WB only: wb_we=1, rdaddr=5, data=0xAA for 1 cycle -> next cycle regwrite=1, rdaddr=5, rddata=0xAA; then regwrite=0.
REQ-033 Conflict: LU rdaddr=7 data=0x11 accepted cycle 0; WB rdaddr=3 in cycles 1-2 -> writes r3 in cycles 2-3, r7 in cycle 4.
REQ-034 Full: WB continuously active, 3 LU results offered with LU_DEPTH=2 -> lu_ready=0 after the 2nd accept; the 3rd is held until a pop.
REQ-035 Kill: LU rdaddr=9 buffered, then WB rdaddr=9 granted -> exactly one r9 write (WB data); entry popped later without regwrite.
REQ-036 Starvation (macro on, STARVE_MAX=4): head valid, WB continuously active -> stall=1 in the 5th cycle, head written next cycle, counter cleared; macro off -> stall never 1.
REQ-037 Reset with 2 buffered entries and a pending write -> no regwrite after reset, lu_ready=1 in the first cycle after release, x0 never written.
